encode_4to2: RTL and testbench

//   Registered 4-to-2 priority encoder. Maps four request lines (d3..d0) to a
//   2-bit index (a1,a0) plus a valid flag. Used as a small index-generation

---
 rtl/encode_4to2_if.sv | 41 ++++
 rtl/encode_4to2.sv | 96 +++++++++
 tb/tb_encode_4to2.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/encode_4to2_if.sv
// ---------------------------------------------------------------------------
// encode_4to2_if
//   Request/result bundle for the encode_4to2 priority encoder.
//   Signals:
//     en            sample enable (driven by master)
//     d0..d3        request lines, index 0..3 (driven by master)
//     a1, a0        encoded index MSB/LSB (driven by slave)
//     valid         at least one request line was high (driven by slave)
//     err           more than one request line was high (driven by slave),
//                   present only when ENCODE_MULTIHOT_ERR_EN is defined
//   Modports: master (request source), slave (the encoder).
// ---------------------------------------------------------------------------
interface encode_4to2_if;
   logic en;
   logic d0;
   logic d1;
   logic d2;
   logic d3;
   logic a1;
   logic a0;
   logic valid;
`ifdef ENCODE_MULTIHOT_ERR_EN
   logic err;
`endif

   modport master (
      output en, d0, d1, d2, d3,
      input  a1, a0, valid
`ifdef ENCODE_MULTIHOT_ERR_EN
      , err
`endif
   );

   modport slave (
      input  en, d0, d1, d2, d3,
      output a1, a0, valid
`ifdef ENCODE_MULTIHOT_ERR_EN
      , err
`endif
   );
endinterface

// File: rtl/encode_4to2.sv
// ---------------------------------------------------------------------------
// encode_4to2
//   4-to-2 priority encoder with optional output register.
//   Parameters:
//     HIGH_PRI  1: d3 wins on multi-hot input; 0: d0 wins
//     REG_OUT   1: outputs captured on rising clk when en=1 (1-cycle latency)
//               0: outputs follow inputs combinationally, en ignored
//   Ports:
//     clk       system clock, rising-edge active
//     rst_n     asynchronous active-low reset, clears a1/a0/valid(/err)
//     bus       encode_4to2_if.slave: en, d0..d3 in; a1, a0, valid out
//   Optional feature, macro ENCODE_MULTIHOT_ERR_EN:
//     adds bus.err, high when more than one request line is high, with the
//     same timing and reset value as valid. Encoding still follows HIGH_PRI.
// ---------------------------------------------------------------------------
module encode_4to2 #(
   parameter bit HIGH_PRI = 1'b1,
   parameter bit REG_OUT  = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   encode_4to2_if.slave bus
);

   logic [3:0] req;
   logic [1:0] idx_c;
   logic       valid_c;

   assign req = {bus.d3, bus.d2, bus.d1, bus.d0};

   always_comb begin
      idx_c = '0;
      if (HIGH_PRI) begin
         if (req[3])      idx_c = 2'd3;
         else if (req[2]) idx_c = 2'd2;
         else if (req[1]) idx_c = 2'd1;
         else             idx_c = 2'd0;
      end else begin
         if (req[0])      idx_c = 2'd0;
         else if (req[1]) idx_c = 2'd1;
         else if (req[2]) idx_c = 2'd2;
         else if (req[3]) idx_c = 2'd3;
         else             idx_c = 2'd0;
      end
   end

   assign valid_c = |req;

`ifdef ENCODE_MULTIHOT_ERR_EN
   logic err_c;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign err_c = |(req & (req - 4'd1));
`endif

   generate
      if (REG_OUT) begin : g_reg
         logic [1:0] idx_q;
         logic       valid_q;
`ifdef ENCODE_MULTIHOT_ERR_EN
         logic       err_q;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               idx_q   <= '0;
               valid_q <= 1'b0;
`ifdef ENCODE_MULTIHOT_ERR_EN
               err_q   <= 1'b0;
`endif
            end else if (bus.en) begin
               idx_q   <= idx_c;
               valid_q <= valid_c;
`ifdef ENCODE_MULTIHOT_ERR_EN
               err_q   <= err_c;
`endif
            end
         end

         assign bus.a1    = idx_q[1];
         assign bus.a0    = idx_q[0];
         assign bus.valid = valid_q;
`ifdef ENCODE_MULTIHOT_ERR_EN
         assign bus.err   = err_q;
`endif
      end else begin : g_comb
         // Reset still gates the combinational path so outputs read 0 in reset.
         assign bus.a1    = rst_n & idx_c[1];
         assign bus.a0    = rst_n & idx_c[0];
         assign bus.valid = rst_n & valid_c;
`ifdef ENCODE_MULTIHOT_ERR_EN
         assign bus.err   = rst_n & err_c;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_encode_4to2.sv
// ---------------------------------------------------------------------------
// tb_encode_4to2
//   Drives three encoders with identical stimulus:
//     dut_hi  HIGH_PRI=1, REG_OUT=1
//     dut_lo  HIGH_PRI=0, REG_OUT=1
//     dut_cmb HIGH_PRI=1, REG_OUT=0
//   Registered results are predicted into per-instance queues when stimulus
//   is applied and popped after the capturing edge. Results are compared as
//   {err, valid, a1, a0}; err reads 0 when ENCODE_MULTIHOT_ERR_EN is undefined.
// ---------------------------------------------------------------------------
module tb_encode_4to2;

   logic clk;
   logic rst_n;

   int unsigned total;
   int unsigned bad;

   logic [3:0] q_hi[$];
   logic [3:0] q_lo[$];
   logic [3:0] last_hi;
   logic [3:0] last_lo;

   encode_4to2_if bus_hi ();
   encode_4to2_if bus_lo ();
   encode_4to2_if bus_cmb ();

   encode_4to2 #(.HIGH_PRI(1'b1), .REG_OUT(1'b1)) dut_hi (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_hi)
   );

   encode_4to2 #(.HIGH_PRI(1'b0), .REG_OUT(1'b1)) dut_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_lo)
   );

   encode_4to2 #(.HIGH_PRI(1'b1), .REG_OUT(1'b0)) dut_cmb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_cmb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {err,valid,a1,a0}=%b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder: scan for the winning line instead of an if-chain.
   function automatic logic [3:0] model(input logic [3:0] d, input bit hi_pri);
      logic [1:0] idx;
      bit         found;
      int         cnt;
      logic       e;
      idx   = 2'd0;
      found = 1'b0;
      cnt   = 0;
      for (int i = 0; i < 4; i++) if (d[i]) cnt++;
      if (hi_pri) begin
         for (int i = 3; i >= 0; i--)
            if (d[i] && !found) begin idx = 2'(i); found = 1'b1; end
      end else begin
         for (int i = 0; i < 4; i++)
            if (d[i] && !found) begin idx = 2'(i); found = 1'b1; end
      end
`ifdef ENCODE_MULTIHOT_ERR_EN
      e = (cnt > 1);
`else
      e = 1'b0;
`endif
      return {e, (cnt > 0), idx};
   endfunction

   function automatic logic [3:0] obs_hi();
`ifdef ENCODE_MULTIHOT_ERR_EN
      return {bus_hi.err, bus_hi.valid, bus_hi.a1, bus_hi.a0};
`else
      return {1'b0, bus_hi.valid, bus_hi.a1, bus_hi.a0};
`endif
   endfunction

   function automatic logic [3:0] obs_lo();
`ifdef ENCODE_MULTIHOT_ERR_EN
      return {bus_lo.err, bus_lo.valid, bus_lo.a1, bus_lo.a0};
`else
      return {1'b0, bus_lo.valid, bus_lo.a1, bus_lo.a0};
`endif
   endfunction

   function automatic logic [3:0] obs_cmb();
`ifdef ENCODE_MULTIHOT_ERR_EN
      return {bus_cmb.err, bus_cmb.valid, bus_cmb.a1, bus_cmb.a0};
`else
      return {1'b0, bus_cmb.valid, bus_cmb.a1, bus_cmb.a0};
`endif
   endfunction

   task automatic drive(input logic [3:0] d, input logic e);
      {bus_hi.d3, bus_hi.d2, bus_hi.d1, bus_hi.d0}     = d;
      {bus_lo.d3, bus_lo.d2, bus_lo.d1, bus_lo.d0}     = d;
      {bus_cmb.d3, bus_cmb.d2, bus_cmb.d1, bus_cmb.d0} = d;
      bus_hi.en  = e;
      bus_lo.en  = e;
      bus_cmb.en = e;
   endtask

   // Predict what the registered instances will show after the next edge.
   task automatic predict(input logic [3:0] d, input logic e);
      if (e) begin
         last_hi = model(d, 1'b1);
         last_lo = model(d, 1'b0);
      end
      q_hi.push_back(last_hi);
      q_lo.push_back(last_lo);
   endtask

   task automatic compare_regs(input string tag);
      logic [3:0] exp;
      if (q_hi.size() == 0) check({tag, "_hi_sb_empty"}, obs_hi(), 4'bxxxx);
      else begin exp = q_hi.pop_front(); check({tag, "_hi"}, obs_hi(), exp); end
      if (q_lo.size() == 0) check({tag, "_lo_sb_empty"}, obs_lo(), 4'bxxxx);
      else begin exp = q_lo.pop_front(); check({tag, "_lo"}, obs_lo(), exp); end
   endtask

   task automatic step(input string tag, input logic [3:0] d, input logic e);
      @(negedge clk);
      drive(d, e);
      predict(d, e);
      #1;
      check({tag, "_cmb"}, obs_cmb(), model(d, 1'b1));
      @(posedge clk);
      #1;
      compare_regs(tag);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      last_hi = '0;
      last_lo = '0;

      // Reset with non-zero inputs: everything reads 0 before any clock edge.
      rst_n = 1'b0;
      drive(4'b1000, 1'b1);
      #2;
      check("rst_hi", obs_hi(), 4'b0000);
      check("rst_lo", obs_lo(), 4'b0000);
      check("rst_cmb", obs_cmb(), 4'b0000);

      @(negedge clk);
      drive(4'b0000, 1'b0);
      rst_n = 1'b1;

      // en=0 after release: registers keep their reset value.
      step("hold_after_rst", 4'b0100, 1'b0);

      // One-hot and all-zero sweep.
      step("z0000", 4'b0000, 1'b1);
      step("d0",    4'b0001, 1'b1);
      step("d1",    4'b0010, 1'b1);
      step("d2",    4'b0100, 1'b1);
      step("d3",    4'b1000, 1'b1);

      // Multi-hot priority.
      step("m1011", 4'b1011, 1'b1);
      step("m0110", 4'b0110, 1'b1);
      step("m0100", 4'b0100, 1'b1);
      step("m1111", 4'b1111, 1'b1);
      step("m0011", 4'b0011, 1'b1);
      step("m1100", 4'b1100, 1'b1);

      // Enable hold: encode d2, then d1 with en low, then raise en.
      step("en_d2",    4'b0100, 1'b1);
      step("en0_hold", 4'b0010, 1'b0);
      step("en1_d1",   4'b0010, 1'b1);

      // Asynchronous reset between edges with outputs at 11.
      step("pre_rst_d3", 4'b1000, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      drive(4'b0010, 1'b1);
      #1;
      check("async_rst_hi", obs_hi(), 4'b0000);
      check("async_rst_lo", obs_lo(), 4'b0000);
      check("async_rst_cmb", obs_cmb(), 4'b0000);
      last_hi = '0;
      last_lo = '0;
      #1;
      rst_n = 1'b1;
      predict(4'b0010, 1'b1);
      #1;
      check("post_rst_cmb", obs_cmb(), model(4'b0010, 1'b1));
      @(posedge clk);
      #1;
      compare_regs("post_rst_d1");

      // Random vectors with random enable.
      for (int i = 0; i < 24; i++) begin
         step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got no summary expected one");
      $fatal(1);
   end

endmodule
